memory_rw: RTL and testbench

- Single-port synchronous RAM with a valid/ready request handshake.
- One request per accepted cycle, either a read or a write, selected by wr_rd_i.
- Used as a small on-chip scratch store behind a simple master.
- Default geometry is 16 words x 16 bits. Sized by parameters, e.g. 1 kbit as 64 x 16.

---
 rtl/memory_rw.sv | 77 +++++++
 tb/tb_memory_rw.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/memory_rw.sv
// Single-port synchronous RAM (DEPTH x WIDTH) behind a valid/ready handshake with registered read data.
// Define MEMORY_RW_WAIT_STATE_EN to insert one wait state per request (ready_o pulses once per transfer).
module memory_rw #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      rdata_o,
    input  logic                  wr_rd_i,
    input  logic                  valid_i,
    output logic                  ready_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             accept;
    logic             in_range;

`ifdef MEMORY_RW_WAIT_STATE_EN
    // state | meaning
    // IDLE  | ready_o low; a valid request moves to ACK
    // ACK   | ready_o high; the request executes on the next edge
    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;
    state_t state_q, state_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_i) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ready_o = (state_q == ACK);
`else
    logic ready_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) ready_q <= 1'b0;
        else        ready_q <= 1'b1;
    end

    assign ready_o = ready_q;
`endif

    assign accept   = valid_i & ready_o;
    // Only reachable when DEPTH is not a power of two.
    assign in_range = 32'(addr_i) < 32'(DEPTH);

    always_comb begin
        rdata_d = rdata_q;
        if (accept && !wr_rd_i) rdata_d = in_range ? mem_q[addr_i] : '0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rdata_q <= '0;
        end else begin
            if (accept && wr_rd_i && in_range) mem_q[addr_i] <= wdata_i;
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_memory_rw.sv
// Randomized bench for memory_rw: a 16-word instance and a 12-word instance (out-of-range
// addresses) are compared against array models that apply the read/write rules directly.
module tb_memory_rw;

`ifdef MEMORY_RW_WAIT_STATE_EN
    localparam bit WS = 1'b1;
`else
    localparam bit WS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  a16 = '0, a12 = '0;
    logic [15:0] d16 = '0, d12 = '0;
    logic [15:0] rd16, rd12;
    logic        wr16 = 1'b0, wr12 = 1'b0;
    logic        v16 = 1'b0, v12 = 1'b0;
    logic        rdy16, rdy12;

    logic [15:0] m16 [16];
    logic [15:0] m12 [12];
    logic [15:0] m_rd16, m_rd12;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    memory_rw #(.WIDTH(16), .DEPTH(16), .ADDR_WIDTH(4)) dut (
        .clk_i(clk), .rst_i(rst_n), .addr_i(a16), .wdata_i(d16), .rdata_o(rd16),
        .wr_rd_i(wr16), .valid_i(v16), .ready_o(rdy16)
    );

    memory_rw #(.WIDTH(16), .DEPTH(12), .ADDR_WIDTH(4)) dut12 (
        .clk_i(clk), .rst_i(rst_n), .addr_i(a12), .wdata_i(d12), .rdata_o(rd12),
        .wr_rd_i(wr12), .valid_i(v12), .ready_o(rdy12)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m16[i] = '0;
        for (int i = 0; i < 12; i++) m12[i] = '0;
        m_rd16 = '0;
        m_rd12 = '0;
    endtask

    task automatic model_apply(input bit s12, input bit wr, input logic [3:0] a, input logic [15:0] d);
        if (s12) begin
            if (wr) begin
                if (a < 4'd12) m12[a] = d;
            end else begin
                m_rd12 = (a < 4'd12) ? m12[a] : 16'h0000;
            end
        end else begin
            if (wr) m16[a] = d;
            else    m_rd16 = m16[a];
        end
    endtask

    // Entered at a falling edge; leaves valid high and returns at the falling edge after acceptance.
    task automatic do_req(input bit s12, input bit wr, input logic [3:0] a, input logic [15:0] d);
        int   n;
        logic rdy;
        n = 0;
        if (s12) begin v12 = 1'b1; wr12 = wr; a12 = a; d12 = d; end
        else     begin v16 = 1'b1; wr16 = wr; a16 = a; d16 = d; end
        rdy = s12 ? rdy12 : rdy16;
        while (rdy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
            rdy = s12 ? rdy12 : rdy16;
        end
        chk("req_ready", 32'(rdy), 32'd1);
        if (rdy !== 1'b1) return;
        @(posedge clk);
        model_apply(s12, wr, a, d);
        @(negedge clk);
        if (s12) chk(wr ? "wr_rdata12" : "rd_rdata12", 32'(rd12), 32'(m_rd12));
        else     chk(wr ? "wr_rdata16" : "rd_rdata16", 32'(rd16), 32'(m_rd16));
    endtask

    task automatic idle(input int n, input bit hold_chk);
        for (int i = 0; i < n; i++) begin
            v16 = 1'b0; v12 = 1'b0;
            wr16 = 1'($urandom); wr12 = 1'($urandom);
            a16 = 4'($urandom); a12 = 4'($urandom);
            d16 = 16'($urandom); d12 = 16'($urandom);
            @(negedge clk);
            if (hold_chk) chk("hold_rdata", 32'(rd16), 32'(m_rd16));
        end
    endtask

    initial begin
        logic [15:0] w;
        int          k;
        model_clear();

        #1;
        chk("rst_ready16", 32'(rdy16), 32'd0);
        chk("rst_rdata16", 32'(rd16), 32'd0);
        chk("rst_ready12", 32'(rdy12), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_ready", 32'(rdy16), WS ? 32'd0 : 32'd1);

        // fill and readback
        for (int i = 0; i < 16; i++) do_req(1'b0, 1'b1, 4'(i), 16'($urandom));
        for (int i = 0; i < 16; i++) do_req(1'b0, 1'b0, 4'(i), 16'h0);
        idle(2, 1'b0);

        // back-to-back write then read
        do_req(1'b0, 1'b1, 4'd3, 16'hA5A5);
        do_req(1'b0, 1'b0, 4'd3, 16'h0);
        chk("b2b_a5a5", 32'(rd16), 32'h0000A5A5);
        do_req(1'b0, 1'b1, 4'd3, 16'h1234);
        do_req(1'b0, 1'b0, 4'd3, 16'h0);
        chk("b2b_1234", 32'(rd16), 32'h00001234);

        // hold
        do_req(1'b0, 1'b1, 4'd5, 16'hBEEF);
        do_req(1'b0, 1'b0, 4'd5, 16'h0);
        idle(10, 1'b1);
        chk("hold_beef", 32'(rd16), 32'h0000BEEF);
        do_req(1'b0, 1'b1, 4'd6, 16'h7777);
        chk("hold_after_wr", 32'(rd16), 32'h0000BEEF);
        idle(1, 1'b0);

        // random traffic
        for (int i = 0; i < 60; i++) begin
            do_req(1'b0, 1'($urandom), 4'($urandom), 16'($urandom));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3), 1'b1);
        end
        idle(1, 1'b0);

        // out of range on the 12-word instance
        for (int i = 0; i < 12; i++) do_req(1'b1, 1'b1, 4'(i), 16'($urandom));
        do_req(1'b1, 1'b1, 4'd13, 16'hFFFF);
        do_req(1'b1, 1'b0, 4'd13, 16'h0);
        chk("oor_read13", 32'(rd12), 32'd0);
        for (int i = 0; i < 12; i++) do_req(1'b1, 1'b0, 4'(i), 16'h0);
        for (int i = 0; i < 6; i++) do_req(1'b1, 1'($urandom), 4'($urandom_range(10, 15)), 16'($urandom));
        idle(1, 1'b0);

`ifdef MEMORY_RW_WAIT_STATE_EN
        k = 0;
        for (int c = 0; c < 8; c++) begin
            v16 = 1'b1; wr16 = 1'b1; a16 = 4'(8 + k); d16 = 16'hC000 + 16'(k);
            chk("ws_ready", 32'(rdy16), 32'(c % 2));
            if (rdy16 === 1'b1) begin
                model_apply(1'b0, 1'b1, 4'(8 + k), 16'hC000 + 16'(k));
                k++;
            end
            @(negedge clk);
        end
        chk("ws_commits", 32'(k), 32'd4);
        idle(1, 1'b0);
        for (int i = 8; i < 12; i++) do_req(1'b0, 1'b0, 4'(i), 16'h0);
        idle(1, 1'b0);
`endif

        // asynchronous reset while a write is in flight
        do_req(1'b0, 1'b1, 4'd5, 16'hBEEF);
        do_req(1'b0, 1'b0, 4'd5, 16'h0);
        w = 16'h5A5A;
        v16 = 1'b1; wr16 = 1'b1; a16 = 4'd9; d16 = w;
        #2 rst_n = 1'b0;
        #1;
        chk("async_ready", 32'(rdy16), 32'd0);
        chk("async_rdata", 32'(rd16), 32'd0);
        chk("async_rdata12", 32'(rd12), 32'd0);
        model_clear();
        @(negedge clk);
        v16 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        do_req(1'b0, 1'b0, 4'd9, 16'h0);
        chk("post_rst_rd9", 32'(rd16), 32'd0);
        for (int i = 0; i < 16; i++) do_req(1'b0, 1'b0, 4'(i), 16'h0);
        do_req(1'b1, 1'b0, 4'd4, 16'h0);
        idle(2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
